// File: rtl/reg_dump_tx_if.sv
// Word stream from the register-dump transmitter to its sink.
// The transmitter drives valid/data/last and the sink drives ready.
interface reg_dump_tx_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/reg_dump_tx.sv
// Captures a processor-state snapshot and streams it as a fixed 19-word frame:
// header, PC, R0..R15, then an XOR checksum over the preceding 18 words.
module reg_dump_tx #(
  parameter logic [3:0] HDR_TAG = 4'hA,
  parameter int         NWORDS  = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           snap_req,
  input  logic [255:0]   regs_in,
  input  logic [15:0]    pc_in,
  input  logic [2:0]     flags_in,
  reg_dump_tx_if.master  tx,
  output logic           busy,
  output logic           snap_drop
);

  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [4:0] LAST_IDX = 5'(NWORDS - 1);

  state_t         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [15:0]    acc_q, acc_d;
  logic [7:0]     seq_q, seq_d;
  logic [255:0]   regs_q, regs_d;
  logic [15:0]    pc_q, pc_d;
  logic [2:0]     flags_q, flags_d;
  logic           drop_q, drop_d;

  logic           send, hs, final_hs, capture;
  logic [3:0]     ri;
  logic [15:0]    word;

  assign send     = (state_q == SEND);
  assign hs       = send && tx.out_ready;
  assign final_hs = hs && (idx_q == LAST_IDX);
  // A request is honoured from IDLE or when it lands exactly on the closing handshake.
  assign capture  = snap_req && ((state_q == IDLE) || final_hs);

  always_comb begin
    ri = 4'(idx_q - 5'd2);
    if (idx_q == 5'd0)          word = {HDR_TAG, flags_q, 1'b0, seq_q};
    else if (idx_q == 5'd1)     word = pc_q;
    else if (idx_q == LAST_IDX) word = acc_q;
    else                        word = regs_q[{ri, 4'b0000} +: 16];
  end

  assign tx.out_valid = send;
  assign tx.out_data  = send ? word : 16'h0000;
  assign tx.out_last  = send && (idx_q == LAST_IDX);
  assign busy         = send;
  assign snap_drop    = drop_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    seq_d   = seq_q;
    regs_d  = regs_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: if (snap_req) state_d = SEND;
      SEND: begin
        drop_d = snap_req && !final_hs;
        if (final_hs) begin
          seq_d   = seq_q + 8'd1;
          state_d = snap_req ? SEND : IDLE;
        end else if (hs) begin
          acc_d = acc_q ^ word;
          idx_d = idx_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      regs_d  = regs_in;
      pc_d    = pc_in;
      flags_d = flags_in;
      idx_d   = 5'd0;
      acc_d   = 16'h0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      seq_q   <= '0;
      regs_q  <= '0;
      pc_q    <= '0;
      flags_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      seq_q   <= seq_d;
      regs_q  <= regs_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: expected frames are queued when a snapshot is
// requested and checked word by word on each output handshake.
module tb_reg_dump_tx;
  localparam logic [3:0] TAG = 4'hA;

  logic         clk, rst, snap_req, busy, snap_drop;
  logic [255:0] regs_in;
  logic [15:0]  pc_in;
  logic [2:0]   flags_in;

  reg_dump_tx_if tx();

  reg_dump_tx #(.HDR_TAG(TAG), .NWORDS(19)) dut (
    .clk(clk), .rst(rst), .snap_req(snap_req), .regs_in(regs_in),
    .pc_in(pc_in), .flags_in(flags_in), .tx(tx), .busy(busy), .snap_drop(snap_drop)
  );

  typedef struct packed { logic [15:0] data; logic last; } exp_t;
  exp_t q[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   t_first = 0;
  int   t_last  = 0;
  logic [7:0] exp_seq = 8'h00;

  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_data  = 16'h0;
  logic        prev_last  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one frame built from the inputs presented at request time.
  task automatic push_frame();
    logic [15:0] w;
    logic [15:0] acc;
    exp_t e;
    acc = 16'h0;
    for (int i = 0; i < 19; i++) begin
      if (i == 0)       w = {TAG, flags_in, 1'b0, exp_seq};
      else if (i == 1)  w = pc_in;
      else if (i < 18)  w = regs_in[(i-2)*16 +: 16];
      else              w = acc;
      if (i < 18) acc = acc ^ w;
      e.data = w;
      e.last = (i == 18);
      q.push_back(e);
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic start_frame();
    step();
    snap_req = 1'b1;
    push_frame();
    step();
    snap_req = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    int n;
    n = 0;
    while (q.size() != 0) begin
      step();
      if (q.size() == 0) break;
      if (toggle) tx.out_ready = ~tx.out_ready;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $error("FAIL frame_timeout observed=%0d expected=0 pending words", q.size());
        q.delete();
      end
    end
  endtask

  // Output monitor: scoreboard compare on handshakes, stability check on stalls.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(tx.out_valid), 32'd1);
        chk("stall_data",  32'(tx.out_data),  32'(prev_data));
        chk("stall_last",  32'(tx.out_last),  32'(prev_last));
      end
      if (tx.out_valid && !prev_valid) t_first = cyc;
      if (tx.out_valid && tx.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 32'(tx.out_data), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("word_data", 32'(tx.out_data), 32'(e.data));
          chk("word_last", 32'(tx.out_last), 32'(e.last));
          if (e.last) t_last = cyc;
        end
      end
      prev_stall = tx.out_valid && !tx.out_ready;
      prev_valid = tx.out_valid;
      prev_data  = tx.out_data;
      prev_last  = tx.out_last;
    end
  end

  logic [15:0] hdr_exp;

  initial begin
    rst = 1'b1;
    snap_req = 1'b0;
    regs_in = '0;
    pc_in = '0;
    flags_in = '0;
    tx.out_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(tx.out_valid), 32'd0);
    chk("rst_data",  32'(tx.out_data),  32'd0);
    chk("rst_last",  32'(tx.out_last),  32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_drop",  32'(snap_drop),    32'd0);
    step();
    step();
    rst = 1'b0;

    // Basic frame
    regs_in[0*16 +: 16] = 16'h0000;
    regs_in[1*16 +: 16] = 16'h0001;
    regs_in[2*16 +: 16] = 16'h0010;
    regs_in[3*16 +: 16] = 16'h0011;
    regs_in[4*16 +: 16] = 16'hFFFF;
    pc_in = 16'h0020;
    flags_in = 3'b010;
    start_frame();
    chk("basic_latency_valid", 32'(tx.out_valid), 32'd1);
    chk("basic_hdr", 32'(tx.out_data), 32'h0000_A400);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_done(1'b0);
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_idle_valid", 32'(tx.out_valid), 32'd0);
    chk("basic_duration", 32'(t_last - t_first), 32'd18);

    // Backpressure: ready toggles every cycle starting high on word0
    start_frame();
    wait_done(1'b1);
    tx.out_ready = 1'b1;
    chk("bp_duration", 32'(t_last - t_first), 32'd36);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Drop: request at idx 5, with inputs changing after capture
    pc_in = 16'h1234;
    regs_in[7*16 +: 16] = 16'hBEEF;
    start_frame();
    repeat (5) step();
    snap_req = 1'b1;
    regs_in = {16{16'h5A5A}};
    pc_in = 16'hDEAD;
    step();
    snap_req = 1'b0;
    chk("drop_pulse", 32'(snap_drop), 32'd1);
    step();
    chk("drop_once", 32'(snap_drop), 32'd0);
    wait_done(1'b0);

    // Back-to-back: request on the checksum handshake
    start_frame();
    repeat (18) step();
    snap_req = 1'b1;
    pc_in = 16'h0F0F;
    flags_in = 3'b101;
    hdr_exp = {TAG, 3'b101, 1'b0, exp_seq};
    push_frame();
    step();
    snap_req = 1'b0;
    chk("b2b_valid", 32'(tx.out_valid), 32'd1);
    chk("b2b_hdr", 32'(tx.out_data), 32'(hdr_exp));
    chk("b2b_nodrop", 32'(snap_drop), 32'd0);
    wait_done(1'b0);

    // Asynchronous reset at idx 10
    start_frame();
    repeat (10) step();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(tx.out_valid), 32'd0);
    chk("mid_rst_data",  32'(tx.out_data),  32'd0);
    chk("mid_rst_last",  32'(tx.out_last),  32'd0);
    chk("mid_rst_busy",  32'(busy),         32'd0);
    q.delete();
    exp_seq = 8'h00;
    step();
    step();
    rst = 1'b0;
    start_frame();
    chk("post_rst_hdr", 32'(tx.out_data), {16'h0, TAG, 3'b101, 1'b0, 8'h00});
    wait_done(1'b0);

    // Sequence wrap over 257 frames from a fresh reset
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_seq = 8'h00;
    regs_in = {16{16'h0123}};
    for (int f = 1; f <= 257; f++) begin
      start_frame();
      if (f == 256) chk("wrap_seq_ff", 32'(tx.out_data[7:0]), 32'h0000_00FF);
      if (f == 257) chk("wrap_seq_00", 32'(tx.out_data[7:0]), 32'h0000_0000);
      wait_done(1'b0);
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
